// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_pkg
//  Purpose  : Shared encodings for the RV32M multiply/divide unit:
//             funct3 operation codes and the sequencer state encoding.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package muldiv_pkg;

   // RV32M funct3 encodings. Bit 2 separates divide from multiply, and
   // bit 1 separates remainder from quotient within the divide group.
   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit_if
//  Purpose  : Request/response bundle of the multiply/divide unit.
//  Signals  : start, op, operand_A, operand_B, flush, result_ready (requester
//             to unit); ready, result_valid, ALU_result (unit to requester).
//  Modports : master = requester side, slave = unit side.
//  Revision : 1.0  initial release
// ============================================================================
interface muldiv_unit_if #(
   parameter int DATA_WIDTH = 32
) ();

   logic                  start;
   logic [2:0]            op;
   logic [DATA_WIDTH-1:0] operand_A;
   logic [DATA_WIDTH-1:0] operand_B;
   logic                  flush;
   logic                  ready;
   logic                  result_valid;
   logic                  result_ready;
   logic [DATA_WIDTH-1:0] ALU_result;

   modport master (
      output start, op, operand_A, operand_B, flush, result_ready,
      input  ready, result_valid, ALU_result
   );

   modport slave (
      input  start, op, operand_A, operand_B, flush, result_ready,
      output ready, result_valid, ALU_result
   );

endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Iterative RV32M multiply/divide unit. One shift-add or one
//             restoring subtract-shift step per clock on operand magnitudes,
//             with sign correction on the final step. Divide-by-zero and
//             signed overflow complete directly on the accept edge.
//  Ports    : clock, reset (async, active high), bus (muldiv_unit_if.slave)
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
   input  wire logic       clock,
   input  wire logic       reset,
   muldiv_unit_if.slave    bus
);

   localparam int W = DATA_WIDTH;

   state_e               r_state;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic [2*W-1:0]       r_acc;    // {high/remainder, low/quotient}
   logic [W-1:0]         r_opd;    // multiplicand or divisor magnitude
   op_e                  r_op;
   logic                 r_neg;    // negate the selected result on the last step
   logic [W-1:0]         r_result;

   // ---------------- accept-time decode ----------------
   op_e          w_op_in;
   logic         w_sgn_a, w_sgn_b, w_neg_in;
   logic [W-1:0] w_mag_a, w_mag_b;
   logic         w_div_zero, w_div_ovf;
   logic [W-1:0] w_bypass_result;

   always_comb begin
      w_op_in  = op_e'(bus.op);
      w_sgn_a  = bus.operand_A[W-1] &&
                 (w_op_in == OP_MULH || w_op_in == OP_MULHSU ||
                  w_op_in == OP_DIV  || w_op_in == OP_REM);
      w_sgn_b  = bus.operand_B[W-1] &&
                 (w_op_in == OP_MULH || w_op_in == OP_DIV || w_op_in == OP_REM);
      w_mag_a  = w_sgn_a ? -bus.operand_A : bus.operand_A;
      w_mag_b  = w_sgn_b ? -bus.operand_B : bus.operand_B;
      // Remainder takes the dividend's sign; everything else the product sign.
      w_neg_in = (bus.op[2] && bus.op[1]) ? w_sgn_a : (w_sgn_a ^ w_sgn_b);

      w_div_zero = bus.op[2] && (bus.operand_B == '0);
      w_div_ovf  = (w_op_in == OP_DIV || w_op_in == OP_REM) &&
                   (bus.operand_A == {1'b1, {(W-1){1'b0}}}) &&
                   (bus.operand_B == '1);

      w_bypass_result = '0;
      if (w_div_zero)
         w_bypass_result = bus.op[1] ? bus.operand_A : '1;
      else if (w_div_ovf)
         w_bypass_result = bus.op[1] ? '0 : bus.operand_A;
   end

   // ---------------- one iteration step ----------------
   logic [W:0]     w_mul_sum;
   logic [W:0]     w_rem_sh;
   logic [W:0]     w_diff;
   logic [2*W-1:0] w_acc_next;
   logic [2*W-1:0] w_prod_fix;
   logic [W-1:0]   w_part, w_part_fix, w_final;

   always_comb begin
      // Multiply: conditionally add multiplicand into the high half, then
      // shift the whole pair right; the multiplier drains out of the low half.
      w_mul_sum = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opd} : '0);

      // Divide: shift the next dividend bit into the partial remainder and
      // keep the difference only if it did not go negative.
      w_rem_sh = {r_acc[2*W-1:W], r_acc[W-1]};
      w_diff   = w_rem_sh - {1'b0, r_opd};

      if (r_op[2])
         w_acc_next = w_diff[W] ? {w_rem_sh[W-1:0], r_acc[W-2:0], 1'b0}
                                : {w_diff[W-1:0],   r_acc[W-2:0], 1'b1};
      else
         w_acc_next = {w_mul_sum, r_acc[W-1:1]};

      // Product sign fix must act on the full double-width value so the
      // high half sees the borrow out of the low half.
      w_prod_fix = r_neg ? -w_acc_next : w_acc_next;
      w_part     = r_op[1] ? w_acc_next[2*W-1:W] : w_acc_next[W-1:0];
      w_part_fix = r_neg ? -w_part : w_part;

      if (r_op[2])
         w_final = w_part_fix;
      else if (r_op == OP_MUL)
         w_final = w_prod_fix[W-1:0];
      else
         w_final = w_prod_fix[2*W-1:W];
   end

   // ---------------- sequencer ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_opd    <= '0;
         r_op     <= OP_MUL;
         r_neg    <= 1'b0;
         r_result <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start && !bus.flush) begin
                  r_op  <= w_op_in;
                  r_neg <= w_neg_in;
                  r_cnt <= '0;
                  if (bus.op[2]) begin
                     r_acc <= {{W{1'b0}}, w_mag_a};
                     r_opd <= w_mag_b;
                  end else begin
                     r_acc <= {{W{1'b0}}, w_mag_b};
                     r_opd <= w_mag_a;
                  end
                  if (w_div_zero || w_div_ovf) begin
                     r_result <= w_bypass_result;
                     r_state  <= ST_DONE;
                  end else begin
                     r_state  <= ST_BUSY;
                  end
               end
            end
            ST_BUSY: begin
               if (bus.flush) begin
                  r_cnt   <= '0;
                  r_state <= ST_IDLE;
               end else begin
                  r_acc <= w_acc_next;
                  r_cnt <= r_cnt + CNT_WIDTH'(1);
                  if (r_cnt == CNT_WIDTH'(W-1)) begin
                     r_result <= w_final;
                     r_state  <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (bus.flush || bus.result_ready) begin
                  r_result <= '0;
                  r_cnt    <= '0;
                  r_state  <= ST_IDLE;
               end
            end
            default: begin
               r_result <= '0;
               r_state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ready        = (r_state == ST_IDLE);
   assign bus.result_valid = (r_state == ST_DONE);
   assign bus.ALU_result   = r_result;

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width (even, >= 8).
REQ-002 SHALL have parameter CNT_WIDTH, default $clog2(DATA_WIDTH)+1, iteration counter width.
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request valid; operands and op sampled when start && ready.
REQ-006 op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 operand_A  input  DATA_WIDTH  rs1 value (multiplicand/dividend).
REQ-008 operand_B  input  DATA_WIDTH  rs2 value (multiplier/divisor).
REQ-009 flush  input  1  synchronous abort of in-flight operation.
REQ-010 ready  output  1  high only in IDLE.
REQ-011 result_valid  output  1  high only in DONE.
REQ-012 result_ready  input  1  consumer accepts result when result_valid && result_ready.
REQ-013 ALU_result  output  DATA_WIDTH  result, stable while result_valid.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 IDLE -> BUSY on edge with start; op, operand magnitudes and sign flags latched, counter cleared.
REQ-016 BUSY SHALL perform one shift-add (multiply) or one restoring subtract-shift (divide) step per edge, counter incrementing.
REQ-017 BUSY -> DONE on the edge where counter == DATA_WIDTH-1, sign correction applied on that same edge; result_valid thus rises exactly DATA_WIDTH edges after the accept edge.
REQ-018 Multiply SHALL form 2*DATA_WIDTH product: MUL low half; MULH signed x signed high; MULHSU signed A x unsigned B high; MULHU unsigned high.
REQ-019 DIV/REM SHALL truncate toward zero; remainder sign follows dividend.
REQ-020 Divide by zero SHALL bypass BUSY (IDLE -> DONE on accept edge): DIV/DIVU quotient all ones, REM/REMU remainder = operand_A.
REQ-021 Signed overflow (A = most-negative, B = all ones, DIV/REM) SHALL bypass BUSY: DIV result = operand_A, REM result = 0.
REQ-022 DONE -> IDLE on edge with result_ready; result_valid SHALL hold and ALU_result SHALL remain constant until then.
REQ-023 start while not ready SHALL be ignored, no state or operand change.
REQ-024 flush SHALL force IDLE on next edge from BUSY or DONE, discarding result; flush has priority over start, result_ready and FSM progress; flush in IDLE with start SHALL not accept.
REQ-025 ALU_result SHALL read 0 whenever result_valid is low.

Reset
REQ-026 On reset assertion, immediately and regardless of clock: state IDLE, ready=1, result_valid=0, ALU_result=0, counter and datapath registers 0.
REQ-027 Reset mid-operation SHALL abandon the operation; no result is produced after release.
REQ-028 First accept possible on first rising edge after reset deasserts.

Structure
REQ-029 Shared package muldiv_pkg SHALL hold op encodings (MUL..REMU) and the FSM state encoding.
REQ-030 Single module; no sub-module is natural — datapath (accumulator, partial remainder, shifter, conditional negate) stays inline.
REQ-031 Registers: state, counter, 2*DATA_WIDTH accumulator/remainder-quotient pair, latched divisor/multiplicand, op, negate flag.

Verification (DATA_WIDTH=32)
REQ-032 MUL 7 x 0xFFFFFFFD -> ALU_result 0xFFFFFFEB, result_valid exactly 32 edges after accept, ready low in between.
REQ-033 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-034 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 20 / 3 -> 6; REMU -> 2.
REQ-035 DIVU 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5, DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0, each valid one edge after accept.
REQ-036 Backpressure: result_ready low 5 cycles after valid -> valid and ALU_result held, start ignored; ready returns edge after result_ready.
REQ-037 flush at counter 10, and separately reset at counter 10 -> IDLE, no result_valid pulse, next MUL 3 x 4 -> 12 correctly.
